// File: rtl/mips_cpu_fetch.sv
// PC / instruction-fetch stage: word fetch over read/waitrequest, branch-delay-slot commit, halt on jump to HALT_ADDR.
// Optional FETCH_ALIGN_CHECK_EN adds a `fault` output that halts on a misaligned committed target.
module mips_cpu_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  output logic        instr_read,
  input  logic        instr_waitrequest,
  input  logic [31:0] instr_readdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic        is_true,
  input  logic [15:0] imm,
  input  logic [25:0] j_addr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_link,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        fault,
`endif
  output logic        active
);

  // state | meaning
  // FETCH | read request outstanding at pc
  // EXEC  | instr_out presented to decoder, commit when not stalled
  // HALT  | jumped to halt target, only reset leaves
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt, instr_nxt, delay_target, dt_nxt;
  logic        delay_pending, dp_nxt;
  logic [31:0] pc_plus4, branch_target, jump_target;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault_nxt;
`endif

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  assign jump_target   = {pc_plus4[31:28], j_addr, 2'b00};

  assign instr_address = pc;
  assign instr_read    = reset && (state == FETCH);
  assign instr_valid   = (state == EXEC);
  assign active        = (state != HALT);
  assign pc_link       = pc + 32'd8;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_out;
    dp_nxt    = delay_pending;
    dt_nxt    = delay_target;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_nxt = fault;
`endif
    case (state)
      FETCH: begin
        if (!instr_waitrequest) begin
          instr_nxt = instr_readdata;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          state_nxt = FETCH;
          if (delay_pending) begin
            dp_nxt = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            pc_nxt = delay_target;
            if (delay_target[1:0] != 2'b00) begin
              fault_nxt = 1'b1;
              state_nxt = HALT;
            end else if (delay_target == HALT_ADDR) begin
              state_nxt = HALT;
            end
`else
            // misaligned targets are silently word-aligned
            pc_nxt = {delay_target[31:2], 2'b00};
            if (delay_target == HALT_ADDR) state_nxt = HALT;
`endif
          end else if (pc_sel == 2'b00 || (pc_sel == 2'b01 && !is_true)) begin
            pc_nxt = pc_plus4;
          end else begin
            pc_nxt = pc_plus4;
            dp_nxt = 1'b1;
            case (pc_sel)
              2'b01:   dt_nxt = branch_target;
              2'b10:   dt_nxt = jump_target;
              default: dt_nxt = jr_target;
            endcase
          end
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= FETCH;
      pc            <= RESET_VECTOR;
      instr_out     <= 32'd0;
      delay_pending <= 1'b0;
      delay_target  <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault         <= 1'b0;
`endif
    end else if (clk_enable) begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      instr_out     <= instr_nxt;
      delay_pending <= dp_nxt;
      delay_target  <= dt_nxt;
`ifdef FETCH_ALIGN_CHECK_EN
      fault         <= fault_nxt;
`endif
    end
  end

endmodule
